reset_sequencer: RTL and testbench

// - Owns all block-level resets. Takes one board/POR reset, synchronises its release, then releases
//   N_DOM downstream reset domains in a fixed order (domain 0 first), with a per-domain delay.
// - Also accepts a synchronous software reset request that re-runs the whole assert/release sequence.
// - Sits at the top of each clock domain, directly after the pad reset.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/areset_srelease.sv | 23 ++
 rtl/reset_sequencer.sv | 128 ++++++++++++
 tb/tb_reset_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// extraction of one per-domain delay field from the packed delay bus.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT,
        DONE
    } state_t;

    // Widest packed delay bus the helper accepts (N_DOM*DLY_W must not exceed it).
    localparam int DLY_MAX = 256;

    function automatic logic [DLY_MAX-1:0] dly_field(input logic [DLY_MAX-1:0] dly,
                                                     input int unsigned        k,
                                                     input int unsigned        w);
        logic [DLY_MAX-1:0] mask;
        mask = (DLY_MAX'(1) << w) - DLY_MAX'(1);
        return (dly >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/areset_srelease.sv
// Reset synchroniser: asserts immediately with the pad reset, releases only
// after STAGES clean clock edges so downstream flops never see a racy release.
module areset_srelease #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic i_rst,
    output logic o_rst
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign o_rst = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Top-level reset sequencer: synchronises the pad reset, then releases N_DOM
// active-low domain resets in order with per-domain delays; supports sw re-sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int DLY_W    = 8,
    parameter int HOLD_CYC = 8
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_sw_rst_req,
    input  logic [N_DOM*DLY_W-1:0] i_dly,
    output logic [N_DOM-1:0]       o_rst,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_DOM - 1);
    localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYC - 1);

    logic               rst_sync;
    logic [DLY_MAX-1:0] dly_ext;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
    logic               sw_hold_q, sw_hold_d;
    logic [N_DOM-1:0]   rst_q, rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    areset_srelease #(.STAGES(2)) u_sync (
        .clk   (clk),
        .i_rst (i_rst),
        .o_rst (rst_sync)
    );

    assign dly_ext = DLY_MAX'(i_dly);

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            hcnt_q    <= '0;
            sw_hold_q <= 1'b0;
            rst_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hcnt_q    <= hcnt_d;
            sw_hold_q <= sw_hold_d;
            rst_q     <= rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hcnt_d    = hcnt_q;
        sw_hold_d = sw_hold_q;
        rst_d     = rst_q;
        busy_d    = busy_q;
        done_d    = done_q;

        if (i_sw_rst_req && (state_q != HOLD)) begin
            state_d   = HOLD;
            hcnt_d    = HOLD_LOAD;
            sw_hold_d = 1'b1;
            rst_d     = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    // A request while holding restarts the sw hold window.
                    if (i_sw_rst_req) begin
                        sw_hold_d = 1'b1;
                        hcnt_d    = HOLD_LOAD;
                    end else if (rst_sync && (!sw_hold_q || (hcnt_q == '0))) begin
                        state_d   = WAIT;
                        idx_d     = '0;
                        cnt_d     = DLY_W'(dly_field(dly_ext, 0, DLY_W));
                        sw_hold_d = 1'b0;
                    end else if (sw_hold_q) begin
                        hcnt_d = hcnt_q - HCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end else begin
                        rst_d[idx_q] = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = DLY_W'(dly_field(dly_ext, int'(idx_q) + 1, DLY_W));
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    assign o_rst  = rst_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: POR, async glitch, sw pulse, held sw
// request, zero delays and simultaneous pad/sw reset, with hand-derived offsets.
module tb_reset_sequencer;

    localparam int N_DOM    = 4;
    localparam int DLY_W    = 8;
    localparam int HOLD_CYC = 8;

    logic                   clk = 1'b0;
    logic                   i_rst = 1'b1;
    logic                   i_sw_rst_req = 1'b0;
    logic [N_DOM*DLY_W-1:0] i_dly = {8'd1, 8'd5, 8'd0, 8'd3};
    logic [N_DOM-1:0]       o_rst;
    logic                   o_busy;
    logic                   o_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_DOM    (N_DOM),
        .DLY_W    (DLY_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_sw_rst_req (i_sw_rst_req),
        .i_dly        (i_dly),
        .o_rst        (o_rst),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // Expected o_rst n edges after a reference edge, given each bit's release edge.
    function automatic logic [3:0] exp_rst(int n, int e0, int e1, int e2, int e3);
        return {n >= e3, n >= e2, n >= e1, n >= e0};
    endfunction

    task automatic test_reset();
        i_rst = 1'b1;
        #2;
        i_rst = 1'b0;
        #1;
        n_cmp++; if (o_rst !== 4'b0000) begin n_err++; $display("FAIL reset_rst got=%b want=0000", o_rst); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b want=1", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", o_done); end
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            n_cmp++; if (o_rst !== 4'b0000) begin n_err++; $display("FAIL reset_hold n=%0d got=%b want=0000", n, o_rst); end
        end
    endtask

    task automatic test_por();
        logic [3:0] e;
        @(negedge clk);
        i_rst = 1'b1;
        // Two synchroniser edges, HOLD exit on edge 3, then releases at +4,+5,+11,+13.
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #1;
            e = exp_rst(n, 7, 8, 14, 16);
            n_cmp++; if (o_rst !== e) begin n_err++; $display("FAIL por_rst n=%0d got=%b want=%b", n, o_rst, e); end
            n_cmp++; if (o_done !== (n >= 16)) begin n_err++; $display("FAIL por_done n=%0d got=%b want=%b", n, o_done, n >= 16); end
            n_cmp++; if (o_busy !== (n < 16)) begin n_err++; $display("FAIL por_busy n=%0d got=%b want=%b", n, o_busy, n < 16); end
        end
    endtask

    task automatic test_sw_reset();
        logic [3:0] e;
        @(negedge clk);
        i_sw_rst_req = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (o_rst !== 4'b0000) begin n_err++; $display("FAIL sw_rst got=%b want=0000", o_rst); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL sw_busy got=%b want=1", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL sw_done got=%b want=0", o_done); end
        @(negedge clk);
        i_sw_rst_req = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk); #1;
            e = exp_rst(n, 12, 13, 19, 21);
            n_cmp++; if (o_rst !== e) begin n_err++; $display("FAIL sw_seq n=%0d got=%b want=%b", n, o_rst, e); end
            n_cmp++; if (o_done !== (n >= 21)) begin n_err++; $display("FAIL sw_seq_done n=%0d got=%b want=%b", n, o_done, n >= 21); end
        end
    endtask

    task automatic test_async_glitch();
        logic [3:0] e;
        @(negedge clk);
        i_sw_rst_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        i_sw_rst_req = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        n_cmp++; if (o_rst !== 4'b0011) begin n_err++; $display("FAIL glitch_pre got=%b want=0011", o_rst); end
        #2;
        i_rst = 1'b0;
        #2;
        n_cmp++; if (o_rst !== 4'b0000) begin n_err++; $display("FAIL glitch_rst got=%b want=0000", o_rst); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy got=%b want=1", o_busy); end
        #2;
        i_rst = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #1;
            e = exp_rst(n, 7, 8, 14, 16);
            n_cmp++; if (o_rst !== e) begin n_err++; $display("FAIL glitch_seq n=%0d got=%b want=%b", n, o_rst, e); end
        end
        n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL glitch_done got=%b want=1", o_done); end
    endtask

    task automatic test_sw_held();
        logic [3:0] e;
        @(negedge clk);
        i_sw_rst_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        i_sw_rst_req = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (o_rst !== 4'b0001) begin n_err++; $display("FAIL held_pre got=%b want=0001", o_rst); end
        @(negedge clk);
        i_sw_rst_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            n_cmp++; if (o_rst !== 4'b0000) begin n_err++; $display("FAIL held_hi n=%0d got=%b want=0000", n, o_rst); end
        end
        @(negedge clk);
        i_sw_rst_req = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk); #1;
            e = exp_rst(n, 12, 13, 19, 21);
            n_cmp++; if (o_rst !== e) begin n_err++; $display("FAIL held_seq n=%0d got=%b want=%b", n, o_rst, e); end
        end
    endtask

    task automatic test_zero_delay();
        logic [3:0] e;
        i_dly = '0;
        @(negedge clk);
        i_sw_rst_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        i_sw_rst_req = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            @(posedge clk); #1;
            e = exp_rst(n, 9, 10, 11, 12);
            n_cmp++; if (o_rst !== e) begin n_err++; $display("FAIL zero_rst n=%0d got=%b want=%b", n, o_rst, e); end
            n_cmp++; if (o_done !== (n >= 12)) begin n_err++; $display("FAIL zero_done n=%0d got=%b want=%b", n, o_done, n >= 12); end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e;
        i_dly = {8'd1, 8'd5, 8'd0, 8'd3};
        @(negedge clk);
        i_rst        = 1'b0;
        i_sw_rst_req = 1'b1;
        #1;
        n_cmp++; if (o_rst !== 4'b0000) begin n_err++; $display("FAIL simul_rst got=%b want=0000", o_rst); end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL simul_done got=%b want=0", o_done); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst        = 1'b1;
        i_sw_rst_req = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #1;
            e = exp_rst(n, 7, 8, 14, 16);
            n_cmp++; if (o_rst !== e) begin n_err++; $display("FAIL simul_seq n=%0d got=%b want=%b", n, o_rst, e); end
        end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL simul_busy got=%b want=0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_por();
        test_sw_reset();
        test_async_glitch();
        test_sw_held();
        test_zero_delay();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
